reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the 5-stage pipeline, replacing the single-write combinational register array. It provides:
- clocked writes from writeback and from the JAL link path;
- NRD combinational read ports with same-cycle write-through bypass;
- an optional hardwired zero register;
- a per-register busy scoreboard that the decode stage uses to detect hazards on in-flight producers.

It sits between decode (reads, busy check, issue) and writeback (result write).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W
- NRD, 2, number of read ports
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wb_en  in  1  writeback write enable
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- link_en  in  1  JAL link write to register NREGS-1
- link_pc  in  DATA_W  word-indexed PC of the JAL
- rd_addr  in  NRD*ADDR_W  read addresses; port i is bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, packed the same way as rd_addr
- rd_busy  out  NRD  1 = register on port i has a pending producer
- busy_set_en  in  1  mark busy_set_addr as pending (issue of a writing instruction)
- busy_set_addr  in  ADDR_W  register to mark pending
- sb_flush  in  1  clear all busy bits (pipeline flush)

## Operation
- Reset: all NREGS registers = 0 and all busy bits = 0, applied asynchronously while rst_n = 0.
- Link value: (link_pc - 1) << 2, computed modulo 2**DATA_W. For example, link_pc = 0 gives 0xFFFFFFFC at DATA_W = 32.
- Write arbitration per register:
  - link_en writes NREGS-1; wb_en writes wb_addr.
  - If both target NREGS-1 in the same cycle, the link value is stored.
  - Writes to register 0 are dropped when ZERO_REG = 1.
- Read port i is combinational, with priority:
  1. ZERO_REG and addr 0: return 0.
  2. link_en and addr = NREGS-1: return the link value.
  3. wb_en and addr = wb_addr: return wb_data.
  4. Otherwise: return the array content.
- Scoreboard, per register r, at the clock edge (first matching rule applies):
  1. sb_flush: busy[r] <= 0.
  2. busy_set_en and r = busy_set_addr: busy[r] <= 1. Set wins over a same-cycle clear.
  3. wb_en and r = wb_addr: busy[r] <= 0.
  4. Otherwise: busy[r] holds.
- A link write does not affect busy bits.
- rd_busy[i] = busy[addr_i] & ~(wb_en & wb_addr = addr_i), i.e. a same-cycle writeback clears the hazard. It is forced to 0 for register 0 when ZERO_REG = 1 and forced to 0 while sb_flush = 1.
- busy_set to register 0 is ignored when ZERO_REG = 1.

## Timing
- Write latency: data is visible in the array from the edge after wb_en/link_en. Same-cycle visibility comes through the bypass, so read-after-write needs 0 cycles.
- rd_data and rd_busy are purely combinational from their inputs and state; no registered outputs.
- Busy set at edge N: rd_busy = 1 from cycle N+1 until the cycle in which the matching wb_en is presented. In that cycle rd_busy = 0 and rd_data = wb_data.
- Reset asserted mid-operation clears the array and busy bits immediately. Outputs then show zeros for array reads; bypass paths stay live if enables are driven.
- No handshakes and no back-pressure; enables are single-cycle qualifiers.

## Structure
- Shared package rf_pkg holds:
  - the DATA_W/ADDR_W defaults;
  - the link-value function (pc - 1) << 2, also used by the branch unit;
  - the LINK_REG constant NREGS-1.
- Sub-module rf_scoreboard holds the NREGS busy vector plus its set/clear/flush logic and produces rd_busy. The top contains the array, write arbitration and read bypass muxes.
- Read ports and bypass are generated per port with a generate loop over NRD.

## Test plan
- Reset then read all 32 registers on both ports -> all rd_data = 0, rd_busy = 0.
- wb_en, wb_addr = 5, wb_data = 0xDEADBEEF, with rd_addr0 = 5 in the same cycle -> rd_data0 = 0xDEADBEEF that cycle, and again the next cycle with wb_en = 0.
- Same cycle: link_en with link_pc = 0x10, and wb_en to register 31 with 0x1234 -> register 31 reads 0x3C (link wins), before and after the edge.
- wb_en to register 0 with 0xFFFF -> register 0 reads 0 in both cycles; busy_set on register 0 -> rd_busy stays 0.
- Scoreboard sequence:
  - busy_set register 7 -> rd_busy = 1 the next cycle;
  - wb_en register 7 with 0x55 -> rd_busy = 0 and rd_data = 0x55 that cycle;
  - busy_set and wb_en on register 7 in the same cycle -> busy remains 1.
- busy_set registers 3 and 4, then sb_flush, with a busy_set of register 9 in the flush cycle -> all busy = 0 after the edge. Then assert rst_n = 0 mid-run -> the array clears without waiting for a clock edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: default widths, link register index and link-value helper.
package rf_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NREGS_DEF  = 1 << ADDR_W_DEF;
    localparam int unsigned LINK_REG   = NREGS_DEF - 1;
    localparam int unsigned LINK_CALC_W = 64;

    // Byte return address of a JAL from its word-indexed PC: (pc - 1) << 2.
    // Computed wide; callers truncate to their data width, which keeps it modulo 2**W.
    function automatic logic [LINK_CALC_W-1:0] link_value(input logic [LINK_CALC_W-1:0] pc);
        return (pc - LINK_CALC_W'(1)) << 2;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback or flush; per-port hazard flags.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic                  busy_set_en,
    input  logic [ADDR_W-1:0]     busy_set_addr,
    input  logic                  sb_flush,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]        rd_busy
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Next busy vector: flush, then set (wins over same-cycle clear), then writeback clear.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned r = 0; r < NREGS; r++) begin
            if (sb_flush) begin
                w_busy_nxt[r] = 1'b0;
            end else if (busy_set_en && (busy_set_addr == ADDR_W'(r)) &&
                         !((ZERO_REG != 0) && (r == 0))) begin
                w_busy_nxt[r] = 1'b1;
            end else if (wb_en && (wb_addr == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Per-port hazard: a same-cycle writeback resolves it; zero register and flush mask it.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_busy
        logic [ADDR_W-1:0] w_addr;
        logic              w_busy;

        assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

        // Hazard flag for this read port.
        always_comb begin
            w_busy = r_busy[w_addr];
            if (wb_en && (wb_addr == w_addr)) begin
                w_busy = 1'b0;
            end
            if (sb_flush || ((ZERO_REG != 0) && (w_addr == '0))) begin
                w_busy = 1'b0;
            end
        end

        assign rd_busy[gi] = w_busy;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: writeback + JAL link writes, bypassed combinational reads, busy scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  link_en,
    input  logic [DATA_W-1:0]     link_pc,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  busy_set_en,
    input  logic [ADDR_W-1:0]     busy_set_addr,
    input  logic                  sb_flush
);

    localparam int unsigned NREGS    = 1 << ADDR_W;
    localparam int unsigned LINK_IDX = NREGS - 1;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_link_val;
    logic              w_wb_wr;

    assign w_link_val = DATA_W'(link_value(LINK_CALC_W'(link_pc)));
    assign w_wb_wr    = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

    // Register array: writeback write, then link write so the link value wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            if (w_wb_wr) begin
                r_regs[wb_addr] <= wb_data;
            end
            if (link_en) begin
                r_regs[ADDR_W'(LINK_IDX)] <= w_link_val;
            end
        end
    end

    // Read ports with zero-register, link and writeback bypass.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

        // Priority mux: zero reg, link bypass, writeback bypass, array.
        always_comb begin
            w_data = r_regs[w_addr];
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_data = '0;
            end else if (link_en && (w_addr == ADDR_W'(LINK_IDX))) begin
                w_data = w_link_val;
            end else if (wb_en && (w_addr == wb_addr)) begin
                w_data = wb_data;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = w_data;
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .sb_flush      (sb_flush),
        .rd_addr       (rd_addr),
        .rd_busy       (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic against a behavioural model.
module tb_reg_file_mp;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        link_en;
    logic [31:0] link_pc;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        busy_set_en;
    logic [4:0]  busy_set_addr;
    logic        sb_flush;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference state: architectural register values and pending-producer flags.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    reg_file_mp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .link_en       (link_en),
        .link_pc       (link_pc),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_busy       (rd_busy),
        .busy_set_en   (busy_set_en),
        .busy_set_addr (busy_set_addr),
        .sb_flush      (sb_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] link_of(input logic [31:0] pc);
        return (pc - 32'd1) * 32'd4;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0)                  return 32'd0;
        if (link_en && a == 5'd31)      return link_of(link_pc);
        if (wb_en && a == wb_addr)      return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (a == 5'd0 || sb_flush)      return 32'd0;
        if (wb_en && a == wb_addr)      return 32'd0;
        return {31'd0, m_busy[a]};
    endfunction

    function automatic logic [31:0] port_data(input int p);
        return rd_data[p*32 +: 32];
    endfunction

    function automatic logic [31:0] port_busy(input int p);
        return {31'd0, rd_busy[p]};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Clock-edge effect of the current inputs on the reference state.
    task automatic model_update();
        if (sb_flush) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        end else begin
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (busy_set_en && busy_set_addr != 5'd0) m_busy[busy_set_addr] = 1'b1;
        end
        if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        if (link_en) m_regs[31] = link_of(link_pc);
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        link_en = 1'b0; link_pc = 32'd0;
        busy_set_en = 1'b0; busy_set_addr = 5'd0; sb_flush = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    // Check both ports against the model, advance one clock, return at the following negedge.
    task automatic step();
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd_data%0d", p), port_data(p), exp_data(rd_addr[p*5 +: 5]));
            chk($sformatf("rd_busy%0d", p), port_busy(p), exp_busy(rd_addr[p*5 +: 5]));
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        idle();
        set_rd(5'd0, 5'd0);
        model_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(negedge clk);

        // All registers read zero and not busy after reset.
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            chk("rst_data0", port_data(0), 32'd0);
            chk("rst_data1", port_data(1), 32'd0);
            chk("rst_busy0", port_busy(0), 32'd0);
            chk("rst_busy1", port_busy(1), 32'd0);
        end

        // Write-through bypass, then array read next cycle.
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd6);
        #1 chk("wt_bypass", port_data(0), 32'hDEADBEEF);
        step();
        idle();
        #1 chk("wt_array", port_data(0), 32'hDEADBEEF);
        step();

        // Link and writeback collide on register 31: link wins.
        link_en = 1'b1; link_pc = 32'h10;
        wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'h1234;
        set_rd(5'd31, 5'd31);
        #1 chk("link_bypass", port_data(1), 32'h3C);
        step();
        idle();
        #1 chk("link_array", port_data(0), 32'h3C);
        step();

        // Link value wraps at pc = 0.
        link_en = 1'b1; link_pc = 32'h0;
        #1 chk("link_wrap", port_data(0), 32'hFFFFFFFC);
        step();
        idle();

        // Register 0 ignores writes and busy sets.
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        busy_set_en = 1'b1; busy_set_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        #1 chk("r0_bypass", port_data(0), 32'd0);
        step();
        idle();
        #1 chk("r0_array", port_data(1), 32'd0);
        chk("r0_busy", port_busy(0), 32'd0);
        step();

        // Scoreboard: set, clear by writeback with bypass, set wins over same-cycle clear.
        busy_set_en = 1'b1; busy_set_addr = 5'd7;
        set_rd(5'd7, 5'd8);
        step();
        idle();
        #1 chk("sb_set", port_busy(0), 32'd1);
        step();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        #1 chk("sb_wb_busy", port_busy(0), 32'd0);
        chk("sb_wb_data", port_data(0), 32'h55);
        busy_set_en = 1'b1; busy_set_addr = 5'd7;
        step();
        idle();
        #1 chk("sb_set_wins", port_busy(0), 32'd1);
        step();

        // Flush beats a same-cycle set.
        busy_set_en = 1'b1; busy_set_addr = 5'd3;
        step();
        busy_set_addr = 5'd4;
        step();
        busy_set_en = 1'b0;
        set_rd(5'd3, 5'd4);
        #1 chk("pre_flush3", port_busy(0), 32'd1);
        chk("pre_flush4", port_busy(1), 32'd1);
        sb_flush = 1'b1; busy_set_en = 1'b1; busy_set_addr = 5'd9;
        #1 chk("flush_mask", port_busy(0), 32'd0);
        step();
        idle();
        for (int a = 1; a < 32; a++) begin
            set_rd(5'(a), 5'(a));
            #1 chk("post_flush", port_busy(0), 32'd0);
        end
        step();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] pick [3];
            wb_en         = ($urandom_range(0, 1) == 1);
            wb_addr       = 5'($urandom_range(0, 31));
            wb_data       = $urandom;
            link_en       = ($urandom_range(0, 3) == 0);
            link_pc       = $urandom;
            busy_set_en   = ($urandom_range(0, 1) == 1);
            busy_set_addr = 5'($urandom_range(0, 31));
            sb_flush      = ($urandom_range(0, 15) == 0);
            pick[0] = wb_addr; pick[1] = busy_set_addr; pick[2] = 5'd31;
            set_rd(($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 2)] : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 2)] : 5'($urandom_range(0, 31)));
            step();
        end

        // Asynchronous reset mid-cycle clears the array at once; bypass stays live.
        idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5A5A5A5;
        busy_set_en = 1'b1; busy_set_addr = 5'd12;
        step();
        idle();
        set_rd(5'd5, 5'd12);
        #1 chk("pre_rst_data", port_data(0), 32'hA5A5A5A5);
        chk("pre_rst_busy", port_busy(1), 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk("async_rst_data", port_data(0), 32'd0);
        chk("async_rst_busy", port_busy(1), 32'd0);
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h0BADF00D;
        #1 chk("rst_bypass", port_data(1), 32'h0BADF00D);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        set_rd(5'd31, 5'd5);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
